// File: rtl/rmii_rx_frame_ctrl.sv
// Receive frame sequencer: streams RMII bytes into the frame buffer and
// qualifies each frame (destination, length, FCS) with a commit or discard.
module rmii_rx_frame_ctrl #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_active,
    input  logic [47:0] local_mac,
    input  logic        promiscuous,
    input  logic        buf_full,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic        commit,
    output logic        discard,
    output logic [10:0] frame_len,
    output logic        crc_err,
    output logic        len_err,
    output logic        ovf_err
);

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, DEST, BODY, DROP} state_t;

    state_t      state, state_n;
    logic [10:0] count, count_n, count_inc;
    logic [31:0] crc, crc_n;
    logic        ml, mb, ml_n, mb_n;
    logic [2:0]  byte_idx;
    logic [7:0]  mac_byte;
    logic        wr_en_n, commit_n, discard_n, crc_err_n, len_err_n, ovf_err_n;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // In IDLE the counter still holds the previous frame's length.
    assign byte_idx  = (state == IDLE) ? 3'd0 : count[2:0];
    assign count_inc = (count == 11'h7FF) ? count : count + 11'd1;

    always_comb begin
        case (byte_idx)
            3'd0:    mac_byte = local_mac[47:40];
            3'd1:    mac_byte = local_mac[39:32];
            3'd2:    mac_byte = local_mac[31:24];
            3'd3:    mac_byte = local_mac[23:16];
            3'd4:    mac_byte = local_mac[15:8];
            3'd5:    mac_byte = local_mac[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        crc_n     = crc;
        ml_n      = ml;
        mb_n      = mb;
        wr_en_n   = 1'b0;
        commit_n  = 1'b0;
        discard_n = 1'b0;
        crc_err_n = 1'b0;
        len_err_n = 1'b0;
        ovf_err_n = 1'b0;
        case (state)
            WAIT_IDLE: if (!rx_active) state_n = IDLE;
            IDLE: begin
                if (rx_active) begin
                    if (buf_full) begin
                        state_n   = DROP;
                        discard_n = 1'b1;
                        ovf_err_n = 1'b1;
                    end else begin
                        wr_en_n = 1'b1;
                        count_n = 11'd1;
                        crc_n   = crc_step(32'hFFFFFFFF, rx_data);
                        ml_n    = (rx_data == mac_byte);
                        mb_n    = (rx_data == 8'hFF);
                        state_n = DEST;
                    end
                end
            end
            DEST, BODY: begin
                if (!rx_active) begin
                    state_n = IDLE;
                    if (count < 11'(MIN_LEN)) begin
                        discard_n = 1'b1;
                        len_err_n = 1'b1;
                    end else if (crc != CRC_RESIDUE) begin
                        discard_n = 1'b1;
                        crc_err_n = 1'b1;
                    end else begin
                        commit_n = 1'b1;
                    end
                end else if (buf_full) begin
                    state_n   = DROP;
                    discard_n = 1'b1;
                    ovf_err_n = 1'b1;
                end else if (count_inc == 11'(MAX_LEN + 1)) begin
                    // The oversize byte itself is not written; the frame is rolled back anyway.
                    state_n   = DROP;
                    discard_n = 1'b1;
                    len_err_n = 1'b1;
                end else begin
                    wr_en_n = 1'b1;
                    count_n = count_inc;
                    crc_n   = crc_step(crc, rx_data);
                    if (state == DEST) begin
                        ml_n = ml & (rx_data == mac_byte);
                        mb_n = mb & (rx_data == 8'hFF);
                        if (count == 11'd5) begin
                            if (promiscuous || ml_n || mb_n) begin
                                state_n = BODY;
                            end else begin
                                state_n   = DROP;
                                discard_n = 1'b1;
                            end
                        end
                    end
                end
            end
            DROP:    if (!rx_active) state_n = IDLE;
            default: state_n = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= WAIT_IDLE;
            count     <= '0;
            crc       <= 32'hFFFFFFFF;
            ml        <= 1'b0;
            mb        <= 1'b0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            commit    <= 1'b0;
            discard   <= 1'b0;
            crc_err   <= 1'b0;
            len_err   <= 1'b0;
            ovf_err   <= 1'b0;
            frame_len <= '0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            crc     <= crc_n;
            ml      <= ml_n;
            mb      <= mb_n;
            wr_en   <= wr_en_n;
            commit  <= commit_n;
            discard <= discard_n;
            crc_err <= crc_err_n;
            len_err <= len_err_n;
            ovf_err <= ovf_err_n;
            if (wr_en_n)  wr_data   <= rx_data;
            if (commit_n) frame_len <= count;
        end
    end

endmodule

// File: tb/tb_rmii_rx_frame_ctrl.sv
// Directed bench for rmii_rx_frame_ctrl: builds Ethernet frames with a real
// FCS, streams them in, and tallies buffer writes and status pulses per frame.
module tb_rmii_rx_frame_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_active;
    logic [47:0] local_mac;
    logic        promiscuous;
    logic        buf_full;
    logic [7:0]  wr_data;
    logic        wr_en, commit, discard, crc_err, len_err, ovf_err;
    logic [10:0] frame_len;

    rmii_rx_frame_ctrl #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_active(rx_active),
        .local_mac(local_mac), .promiscuous(promiscuous), .buf_full(buf_full),
        .wr_data(wr_data), .wr_en(wr_en), .commit(commit), .discard(discard),
        .frame_len(frame_len), .crc_err(crc_err), .len_err(len_err), .ovf_err(ovf_err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_wr, n_commit, n_discard, n_crc, n_len, n_ovf;
    int commit_cyc, fall_cyc, fr_len;
    logic [7:0] fr     [0:2047];
    logic [7:0] wr_log [0:2047];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_wr = 0; n_commit = 0; n_discard = 0; n_crc = 0; n_len = 0; n_ovf = 0;
        commit_cyc = -1;
    endtask

    // Advance to the next falling edge and tally the outputs settled there.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (wr_en) begin
            if (n_wr < 2048) wr_log[n_wr] = wr_data;
            n_wr++;
        end
        if (commit) begin n_commit++; commit_cyc = cyc; end
        if (discard) n_discard++;
        if (crc_err) n_crc++;
        if (len_err) n_len++;
        if (ovf_err) n_ovf++;
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Destination, fixed source, EtherType, counting payload, then FCS; flip_at >= 0
    // corrupts one payload bit after the FCS is computed.
    task automatic build_frame(input logic [47:0] dst, input int len, input int flip_at);
        logic [31:0] c;
        logic [47:0] src;
        logic [31:0] fcs;
        src = 48'h020000000099;
        for (int i = 0; i < 6; i++) fr[i] = dst[47-8*i -: 8];
        for (int i = 0; i < 6; i++) fr[6+i] = src[47-8*i -: 8];
        fr[12] = 8'h08;
        fr[13] = 8'h00;
        for (int i = 14; i < len - 4; i++) fr[i] = 8'(i * 7 + 3);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len - 4; i++) c = crc_byte(c, fr[i]);
        fcs = ~c;
        for (int i = 0; i < 4; i++) fr[len-4+i] = fcs[8*i +: 8];
        if (flip_at >= 0) fr[flip_at] = fr[flip_at] ^ 8'h10;
        fr_len = len;
    endtask

    // Drive the built frame; full_at / rst_at are 1-based byte numbers (0 = never).
    task automatic send_frame(input int full_at, input int rst_at, input int gap);
        clear_mon();
        for (int i = 0; i < fr_len; i++) begin
            rx_active = 1'b1;
            rx_data   = fr[i];
            buf_full  = (i + 1 == full_at);
            if (i + 1 == rst_at) begin
                reset = 1'b1;
                clear_mon();
            end else begin
                reset = 1'b0;
            end
            tick();
        end
        rx_active = 1'b0;
        buf_full  = 1'b0;
        reset     = 1'b0;
        fall_cyc  = cyc;
        repeat (gap) tick();
    endtask

    function automatic int data_errs();
        int e;
        e = 0;
        for (int j = 0; j < n_wr && j < fr_len && j < 2048; j++)
            if (wr_log[j] !== fr[j]) e++;
        return e;
    endfunction

    initial begin
        reset = 1'b1; rx_active = 1'b0; rx_data = 8'h00;
        local_mac = 48'h020000000001; promiscuous = 1'b0; buf_full = 1'b0;
        clear_mon();
        repeat (3) tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_commit", commit, 0);
        chk("rst_discard", discard, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_errs", {crc_err, len_err, ovf_err}, 0);
        reset = 1'b0;
        repeat (2) tick();

        build_frame(48'h020000000001, 64, -1);
        send_frame(0, 0, 3);
        chk("good64_writes", n_wr, 64);
        chk("good64_data", data_errs(), 0);
        chk("good64_commit", n_commit, 1);
        chk("good64_commit_time", commit_cyc, fall_cyc + 1);
        chk("good64_discard", n_discard, 0);
        chk("good64_errs", n_crc + n_len + n_ovf, 0);
        chk("good64_len", frame_len, 64);

        build_frame(48'h020000000001, 64, 20);
        send_frame(0, 0, 3);
        chk("badcrc_writes", n_wr, 64);
        chk("badcrc_discard", n_discard, 1);
        chk("badcrc_crc_err", n_crc, 1);
        chk("badcrc_commit", n_commit, 0);
        chk("badcrc_len_hold", frame_len, 64);

        build_frame(48'hFFFFFFFFFFFF, 100, -1);
        send_frame(0, 0, 3);
        chk("bcast_commit", n_commit, 1);
        chk("bcast_len", frame_len, 100);

        build_frame(48'h020000000002, 80, -1);
        send_frame(0, 0, 3);
        chk("filt_writes", n_wr, 6);
        chk("filt_discard", n_discard, 1);
        chk("filt_commit", n_commit, 0);
        chk("filt_errs", n_crc + n_len + n_ovf, 0);

        promiscuous = 1'b1;
        send_frame(0, 0, 3);
        chk("prom_commit", n_commit, 1);
        chk("prom_len", frame_len, 80);
        promiscuous = 1'b0;

        build_frame(48'h020000000001, 60, -1);
        send_frame(0, 0, 3);
        chk("runt_writes", n_wr, 60);
        chk("runt_discard", n_discard, 1);
        chk("runt_len_err", n_len, 1);
        chk("runt_crc_err", n_crc, 0);

        build_frame(48'h020000000001, 1519, -1);
        send_frame(0, 0, 3);
        chk("over_writes", n_wr, 1518);
        chk("over_discard", n_discard, 1);
        chk("over_len_err", n_len, 1);
        chk("over_commit", n_commit, 0);

        build_frame(48'h020000000001, 1518, -1);
        send_frame(0, 0, 3);
        chk("max_commit", n_commit, 1);
        chk("max_data", data_errs(), 0);
        chk("max_len", frame_len, 1518);

        build_frame(48'h020000000001, 100, -1);
        send_frame(30, 0, 1);
        chk("ovf_writes", n_wr, 29);
        chk("ovf_discard", n_discard, 1);
        chk("ovf_ovf_err", n_ovf, 1);
        chk("ovf_other_errs", n_crc + n_len, 0);
        chk("ovf_len_hold", frame_len, 1518);

        build_frame(48'h020000000001, 64, -1);
        send_frame(0, 0, 3);
        chk("b2b_writes", n_wr, 64);
        chk("b2b_commit", n_commit, 1);
        chk("b2b_len", frame_len, 64);

        build_frame(48'h020000000001, 100, -1);
        send_frame(0, 20, 3);
        chk("rst_mid_writes", n_wr, 0);
        chk("rst_mid_pulses", n_commit + n_discard, 0);
        chk("rst_mid_len", frame_len, 0);

        build_frame(48'h020000000001, 70, -1);
        send_frame(0, 0, 3);
        chk("after_rst_commit", n_commit, 1);
        chk("after_rst_data", data_errs(), 0);
        chk("after_rst_len", frame_len, 70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
